// File: rtl/uart_pkg.sv
// Shared UART transmit-path types and the MMIO addresses decoded upstream.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

    typedef enum logic {
        SRC_CORE,
        SRC_DMA
    } tx_src_t;

    localparam logic [31:0] MMIO_UART_RX      = 32'hfffffff1;
    localparam logic [31:0] MMIO_UART_RX_SIZE = 32'hfffffff2;
    localparam logic [31:0] MMIO_UART_TX      = 32'hfffffff4;
    localparam logic [31:0] MMIO_UART_TX_FREE = 32'hfffffff8;

    // Round-robin helper: the source that did not win last time.
    function automatic tx_src_t other_src(input tx_src_t src);
        return (src == SRC_CORE) ? SRC_DMA : SRC_CORE;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with power-of-two depth, combinational read at rd_ptr and an
// occupancy count one bit wider than the pointers so full differs from empty.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still accepted when a pop frees a slot this edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array has no reset; flushing only clears pointers and
    // count, so stale bytes are unreachable and the array can map to plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UartTx between the core's MMIO transmit FIFO and the DMA byte
// path, granting round-robin and pacing each byte on the tx_busy handshake.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        core_push,
    input  logic [7:0]  core_data,
    output logic [31:0] core_free,
    output logic        core_overflow,
    input  logic        dma_req,
    input  logic [7:0]  dma_data,
    output logic        dma_ack,
    output logic        tx_start,
    output logic [7:0]  sdata,
    input  logic        tx_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state;
    tx_state_t     state_next;
    tx_src_t       last_grant;
    logic          grant_core;
    logic          grant_dma;
    logic          overflow_hit;

    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (core_push),
        .pop   (grant_core),
        .din   (core_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign core_free    = 32'(FIFO_DEPTH) - 32'(fifo_count);
    assign overflow_hit = core_push && fifo_full && !grant_core;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal is given a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        grant_core = 1'b0;
        grant_dma  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!tx_busy) begin
                    if (!fifo_empty && dma_req) begin
                        if (other_src(last_grant) == SRC_DMA) begin
                            grant_dma = 1'b1;
                        end else begin
                            grant_core = 1'b1;
                        end
                    end else if (!fifo_empty) begin
                        grant_core = 1'b1;
                    end else if (dma_req) begin
                        grant_dma = 1'b1;
                    end
                    if (grant_core || grant_dma) begin
                        state_next = WAIT_BUSY;
                    end
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered handshake outputs: tx_start and dma_ack share the grant edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_start      <= 1'b0;
            dma_ack       <= 1'b0;
            sdata         <= 8'h00;
            last_grant    <= SRC_CORE;
            core_overflow <= 1'b0;
        end else begin
            tx_start <= grant_core || grant_dma;
            dma_ack  <= grant_dma;
            if (grant_core) begin
                sdata      <= fifo_dout;
                last_grant <= SRC_CORE;
            end else if (grant_dma) begin
                sdata      <= dma_data;
                last_grant <= SRC_DMA;
            end
            if (overflow_hit) begin
                core_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a UartTx busy model and a
// scoreboard of expected (byte, source) pairs checked on every tx_start.
module tb_uart_tx_scheduler;

    typedef struct {
        logic [7:0] data;
        logic       dma;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        core_push;
    logic [7:0]  core_data;
    logic [31:0] core_free;
    logic        core_overflow;
    logic        dma_req;
    logic [7:0]  dma_data;
    logic        dma_ack;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        tx_busy;

    int   checks   = 0;
    int   failures = 0;
    int   starts   = 0;
    int   busy_cnt = 0;
    int   busy_len = 10;
    logic force_busy;
    logic prev_start = 1'b0;
    exp_t sb[$];

    uart_tx_scheduler #(
        .FIFO_DEPTH (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .core_push     (core_push),
        .core_data     (core_data),
        .core_free     (core_free),
        .core_overflow (core_overflow),
        .dma_req       (dma_req),
        .dma_data      (dma_data),
        .dma_ack       (dma_ack),
        .tx_start      (tx_start),
        .sdata         (sdata),
        .tx_busy       (tx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // UartTx model: busy from the cycle after tx_start for busy_len cycles.
    always @(posedge clock) begin
        if (tx_start) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy = force_busy || (busy_cnt != 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (dma_ack) begin
                check("ack_with_start", {31'd0, tx_start}, 32'd1);
            end
            if (tx_start) begin
                starts++;
                check("single_pulse", {31'd0, prev_start}, 32'd0);
                check("start_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sdata", {24'd0, sdata}, {24'd0, e.data});
                    check("ack_source", {31'd0, dma_ack}, {31'd0, e.dma});
                end
            end
        end
        prev_start = tx_start;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit expect_sent);
        core_push = 1'b1;
        core_data = d;
        if (expect_sent) begin
            sb.push_back('{data: d, dma: 1'b0});
        end
        step();
        core_push = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || tx_busy) && n < 3000) begin
            step();
            n++;
        end
        check(tag, sb.size(), 32'd0);
        step();
        step();
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (!dma_ack && n < 200) begin
            step();
            n++;
        end
        check(tag, {31'd0, dma_ack}, 32'd1);
    endtask

    initial begin
        int s0;
        reset      = 1'b1;
        core_push  = 1'b0;
        core_data  = 8'h00;
        dma_req    = 1'b0;
        dma_data   = 8'h00;
        force_busy = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset values and a quiet idle period.
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_sdata", {24'd0, sdata}, 32'd0);
        check("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
        check("rst_overflow", {31'd0, core_overflow}, 32'd0);
        check("rst_core_free", core_free, 32'd16);
        s0 = starts;
        repeat (100) step();
        check("idle_no_start", starts, s0);

        // Single core byte: tx_start two cycles after the push.
        push_byte(8'h41, 1'b1);
        check("single_free_after_push", core_free, 32'd15);
        check("single_start_early", {31'd0, tx_start}, 32'd0);
        step();
        check("single_start", {31'd0, tx_start}, 32'd1);
        check("single_sdata", {24'd0, sdata}, 32'h41);
        check("single_free_after_pop", core_free, 32'd16);
        step();
        check("single_start_drop", {31'd0, tx_start}, 32'd0);
        drain("single_drain");

        // Overflow: 17 pushes while UartTx is held busy.
        force_busy = 1'b1;
        s0 = starts;
        for (int i = 0; i < 17; i++) begin
            push_byte(8'(i), i < 16);
        end
        check("ovf_free_zero", core_free, 32'd0);
        check("ovf_flag", {31'd0, core_overflow}, 32'd1);
        force_busy = 1'b0;
        drain("ovf_drain");
        check("ovf_sent_count", starts - s0, 32'd16);
        check("ovf_sticky", {31'd0, core_overflow}, 32'd1);
        check("ovf_free_empty", core_free, 32'd16);

        // Contention: last grant was CORE, so DMA goes first, then alternate.
        force_busy = 1'b1;
        push_byte(8'hA0, 1'b0);
        push_byte(8'hA1, 1'b0);
        sb.push_back('{data: 8'h55, dma: 1'b1});
        sb.push_back('{data: 8'hA0, dma: 1'b0});
        sb.push_back('{data: 8'h56, dma: 1'b1});
        sb.push_back('{data: 8'hA1, dma: 1'b0});
        dma_req  = 1'b1;
        dma_data = 8'h55;
        step();
        force_busy = 1'b0;
        wait_ack("cont_ack_55");
        step();
        dma_data = 8'h56;
        step();
        wait_ack("cont_ack_56");
        step();
        dma_req = 1'b0;
        drain("cont_drain");

        // Wrap-around: 40 bytes in bursts of four, interleaved with sends.
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 4; k++) begin
                push_byte(8'($urandom_range(0, 255)), 1'b1);
                check("wrap_free_bound", {31'd0, core_free <= 32'd16}, 32'd1);
            end
            repeat (30) step();
        end
        drain("wrap_drain");
        check("wrap_no_overflow_change", {31'd0, core_overflow}, 32'd1);

        // Reset in WAIT_DONE with three bytes still queued.
        push_byte(8'hC0, 1'b1);
        push_byte(8'hC1, 1'b0);
        push_byte(8'hC2, 1'b0);
        push_byte(8'hC3, 1'b0);
        step();
        step();
        check("mid_busy", {31'd0, tx_busy}, 32'd1);
        check("mid_queued", core_free, 32'd13);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_free", core_free, 32'd16);
        check("mid_tx_start", {31'd0, tx_start}, 32'd0);
        check("mid_overflow_clr", {31'd0, core_overflow}, 32'd0);
        s0 = starts;
        repeat (50) step();
        check("mid_no_start", starts, s0);
        push_byte(8'h77, 1'b1);
        drain("mid_drain");
        check("mid_new_start", starts - s0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares the single UartTx transmitter between two byte sources: the core's MMIO transmit register and the DMA controller's boot-time echo/debug path. Core writes to MMIO 0xfffffff4 go into an internal byte FIFO instead of being dropped when the transmitter is busy. The free-slot count of that FIFO backs MMIO 0xfffffff8. A round-robin FSM feeds one byte at a time to UartTx and follows its tx_busy handshake. The block sits between the memory controller hub's MMIO decode and UartTx.

## Interface
- FIFO_DEPTH, 16: core byte FIFO depth; power of two, 2..256
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- core_push  in  1  one-cycle pulse; MMIO store to 0xfffffff4 (decoded upstream: en & we & addr[31] & addr[2])
- core_data  in  8  byte to enqueue; sampled with core_push
- core_free  out  32  FIFO_DEPTH − occupancy, zero-extended; MMIO 0xfffffff8 read value
- core_overflow  out  1  sticky; set when core_push arrives while FIFO full
- dma_req  in  1  level; DMA controller has a byte on dma_data
- dma_data  in  8  byte from DMA; stable while dma_req high
- dma_ack  out  1  one-cycle pulse; DMA byte taken, DMA may change or drop dma_data/dma_req next cycle
- tx_start  out  1  one-cycle start pulse to UartTx
- sdata  out  8  byte to UartTx; held from tx_start until next grant
- tx_busy  in  1  UartTx busy; rises within 1 cycle after tx_start, falls after stop bit

## Operation
- Reset values: tx_start 0, sdata 0, dma_ack 0, core_overflow 0, core_free FIFO_DEPTH, FSM IDLE, FIFO empty, last_grant CORE.
- FIFO push: on core_push with count < FIFO_DEPTH, write core_data at wr_ptr and advance it (wrap modulo depth).
- FIFO full: a push is dropped, pointers are unchanged, and core_overflow is set. Only reset clears core_overflow.
- Push and pop in the same cycle: both take effect and count is unchanged. Push while full with a simultaneous pop is accepted; it is not an overflow.
- Count is log2(FIFO_DEPTH)+1 bits, so a full FIFO is distinguishable from an empty one. core_free is registered-count derived (combinational from registers).
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE: candidates are FIFO non-empty (CORE) and dma_req (DMA). Nothing is granted while tx_busy=1.
  - One candidate: that candidate is granted.
  - Both: the source ≠ last_grant is granted.
  - On grant: sdata ← chosen byte, tx_start ← 1, last_grant ← source, state ← WAIT_BUSY.
  - CORE grant: FIFO pops at this edge.
  - DMA grant: dma_ack ← 1, registered, so it is high in the same cycle as tx_start.
- WAIT_BUSY: tx_start returns to 0. tx_busy=1 → WAIT_DONE. Requests are ignored.
- WAIT_DONE: tx_busy=0 → IDLE.
- Reset mid-transfer: FSM returns to IDLE and the FIFO is flushed. tx_start is 0 from the next cycle on. A byte already started in UartTx is not aborted by this block.

## Timing
- Grant at edge ending cycle N; tx_start and dma_ack are high in cycle N+1 only.
- Core push in cycle P with UartTx idle and FIFO empty: tx_start in cycle P+2.
- Back-to-back: tx_busy low first in cycle M → IDLE in M+1 → next tx_start in M+2.
- dma_req sampled only in IDLE. A request held across the ack cycle is not regranted until the next IDLE.
- core_free reflects a push or pop in the cycle after it.

## Structure
- Shared package uart_pkg:
  - tx_state_t enum {IDLE, WAIT_BUSY, WAIT_DONE}
  - tx_src_t enum {SRC_CORE, SRC_DMA}
  - MMIO address constants: MMIO_UART_RX = 32'hfffffff1, MMIO_UART_RX_SIZE = 32'hfffffff2, MMIO_UART_TX = 32'hfffffff4, MMIO_UART_TX_FREE = 32'hfffffff8
- Sub-module byte_fifo (parameter DEPTH; push/pop/din/dout/count/full/empty).
  - Read is combinational from rd_ptr.
  - The scheduler contains the arbiter, FSM and overflow flag.

## Test plan
- Reset, then hold idle: all outputs at reset values; core_free = 16; no tx_start for 100 cycles.
- Single core byte: core_push with 8'h41, UartTx model busy 10 cycles.
  - Required: tx_start exactly 2 cycles later with sdata 8'h41, one pulse only.
  - core_free goes 15 → 16.
- Overflow: push 17 bytes 8'h00..8'h10 with tx_busy forced high.
  - Required: core_free reaches 0 and core_overflow = 1.
  - After releasing tx_busy: bytes 00..0F are sent in order; 8'h10 is never sent.
- Contention: FIFO holds 8'hA0, 8'hA1 and dma_req is held with 8'h55, 8'h56.
  - Required order: 55, A0, 56, A1.
  - Each dma_ack coincides with its tx_start.
- Wrap-around: 40 pushes interleaved with sends. Output sequence equals input sequence; core_free never exceeds 16.
- Reset mid-transfer: reset asserted in WAIT_DONE with 3 bytes queued.
  - Required: FIFO empty and core_free = 16.
  - No tx_start until a new push occurs.
